// File: rtl/image_writer.sv
// rtl/image_writer.sv - SD sector write-back from the host sector buffer into the SRAM disk image
module image_writer #(
    parameter int WE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_wr,
    input  logic        write_protect_i,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_din,
    output logic [19:0] sram_addr_o,
    output logic [7:0]  sram_data_o,
    output logic        sram_we_n_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LATCH,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state;
    logic [10:0] base;
    logic [8:0]  idx;
    logic [3:0]  wcnt;
    logic        suppress;
    logic        start_bad;
    logic        unused_sd_wr1;

    // Drive 1 belongs to another image; only drive 0 is served here.
    assign unused_sd_wr1 = sd_wr[1];
    assign start_bad     = write_protect_i | (sd_lba[31:11] != 21'd0);
    assign sd_buff_addr  = idx;
    assign busy_o        = (state != S_IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            base        <= '0;
            idx         <= '0;
            wcnt        <= '0;
            suppress    <= 1'b0;
            sd_ack      <= 1'b0;
            sram_addr_o <= '0;
            sram_data_o <= '0;
            sram_we_n_o <= 1'b1;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sd_wr[0]) begin
                        base     <= sd_lba[10:0];
                        idx      <= '0;
                        sd_ack   <= 1'b1;
                        suppress <= start_bad;
                        err_o    <= start_bad;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                // Host buffer returns data one clock after the address.
                S_WAIT:  state <= S_LATCH;
                S_LATCH: begin
                    sram_data_o <= sd_buff_din;
                    sram_addr_o <= {base, idx};
                    sram_we_n_o <= suppress;
                    wcnt        <= 4'(WE_CYCLES - 1);
                    state       <= S_STROBE;
                end
                S_STROBE: begin
                    if (wcnt == 4'd0) begin
                        sram_we_n_o <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (idx == 9'd511) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    sd_ack <= 1'b0;
                    idx    <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
